// File: rtl/mips32_pkg.sv
// Shared constants for the EX stage: op codes, multiply/divide FSM states, iteration count.
package mips32_pkg;

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpAnd   = 5'd2;
  localparam logic [4:0] OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4;
  localparam logic [4:0] OpNor   = 5'd5;
  localparam logic [4:0] OpSlt   = 5'd6;
  localparam logic [4:0] OpSltu  = 5'd7;
  localparam logic [4:0] OpSll   = 5'd8;
  localparam logic [4:0] OpSrl   = 5'd9;
  localparam logic [4:0] OpSra   = 5'd10;
  localparam logic [4:0] OpLui   = 5'd11;
  localparam logic [4:0] OpMult  = 5'd12;
  localparam logic [4:0] OpMultu = 5'd13;
  localparam logic [4:0] OpDiv   = 5'd14;
  localparam logic [4:0] OpDivu  = 5'd15;
  localparam logic [4:0] OpMfhi  = 5'd16;
  localparam logic [4:0] OpMflo  = 5'd17;

  typedef logic [1:0] md_state_t;
  localparam md_state_t StIdle = 2'd0;
  localparam md_state_t StBusy = 2'd1;
  localparam md_state_t StDone = 2'd2;

  localparam int unsigned MdIters    = 32;
  localparam logic [4:0]  MdLastIter = 5'(MdIters - 1);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle; master drives the instruction side, slave is the EX stage.
interface ex_stage_if;
  logic        i_valid;
  logic [31:0] i_busA;
  logic [31:0] i_busB;
  logic [31:0] i_imm32;
  logic [4:0]  i_rd;
  logic        i_alusrc;
  logic [4:0]  i_aluop;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic [31:0] o_busB;
  logic [4:0]  o_rd;
  logic        o_stall;

  modport master (
    output i_valid, i_busA, i_busB, i_imm32, i_rd, i_alusrc, i_aluop, i_flush,
    input  o_valid, o_result, o_busB, o_rd, o_stall
  );

  modport slave (
    input  i_valid, i_busA, i_busB, i_imm32, i_rd, i_alusrc, i_aluop, i_flush,
    output o_valid, o_result, o_busB, o_rd, o_stall
  );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit holding HI/LO; 32 BUSY cycles then one DONE write-back.
// Divider hardware is only built when MIPS32_DIV_EN is defined.
module mdu
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [4:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  md_state_t   r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opd;
  logic        r_neg_q;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_prod;
  logic [63:0] w_step;

`ifdef MIPS32_DIV_EN
  logic        r_is_div;
  logic        r_neg_r;
  logic [31:0] r_a;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_new;
  logic [63:0] w_div_next;
`endif

  // Signed ops run on magnitudes; the sign is restored at write-back.
  always_comb begin
    w_signed = (i_op == OpMult);
`ifdef MIPS32_DIV_EN
    w_signed = w_signed || (i_op == OpDiv);
`endif
    w_abs_a    = w_signed ? abs32(i_a) : i_a;
    w_abs_b    = w_signed ? abs32(i_b) : i_b;
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    w_prod     = r_neg_q ? -r_acc : r_acc;
    w_step     = w_mul_next;
`ifdef MIPS32_DIV_EN
    w_rem_sh   = {r_acc[63:32], r_acc[31]};
    w_ge       = (w_rem_sh >= {1'b0, r_opd});
    w_rem_new  = w_ge ? 32'(w_rem_sh - {1'b0, r_opd}) : w_rem_sh[31:0];
    w_div_next = {w_rem_new, r_acc[30:0], w_ge};
    if (r_is_div) w_step = w_div_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MIPS32_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
`endif
    end else if (i_flush) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StBusy;
            r_cnt   <= '0;
            r_neg_q <= w_signed && (i_a[31] ^ i_b[31]);
            r_acc   <= {32'd0, w_abs_b};
            r_opd   <= w_abs_a;
`ifdef MIPS32_DIV_EN
            r_is_div <= (i_op == OpDiv) || (i_op == OpDivu);
            r_neg_r  <= w_signed && i_a[31];
            r_a      <= i_a;
            if ((i_op == OpDiv) || (i_op == OpDivu)) begin
              r_acc <= {32'd0, w_abs_a};
              r_opd <= w_abs_b;
            end
`endif
          end
        end
        StBusy: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == MdLastIter) r_state <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
`ifdef MIPS32_DIV_EN
          if (r_is_div) begin
            if (r_opd == '0) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else begin
              r_lo <= r_neg_q ? -r_acc[31:0] : r_acc[31:0];
              r_hi <= r_neg_r ? -r_acc[63:32] : r_acc[63:32];
            end
          end else
`endif
          begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU, EX/MEM output registers and MDU stall.
// Optional divider enabled by MIPS32_DIV_EN.
module ex_stage
  import mips32_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex_bus
);

  logic        r_valid;
  logic [31:0] r_result;
  logic [31:0] r_busB;
  logic [4:0]  r_rd;

  logic        w_stall;
  logic        w_accept;
  logic        w_md_op;
  logic [31:0] w_opb;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  assign w_accept = ex_bus.i_valid && !w_stall && !ex_bus.i_flush;

  always_comb begin
    w_md_op = (ex_bus.i_aluop == OpMult) || (ex_bus.i_aluop == OpMultu);
`ifdef MIPS32_DIV_EN
    w_md_op = w_md_op || (ex_bus.i_aluop == OpDiv) || (ex_bus.i_aluop == OpDivu);
`endif
  end

  // Shifts act on rt (i_busB) with the shift amount from the immediate field.
  always_comb begin
    w_opb   = ex_bus.i_alusrc ? ex_bus.i_imm32 : ex_bus.i_busB;
    w_shamt = ex_bus.i_imm32[10:6];
    case (ex_bus.i_aluop)
      OpAdd:   w_alu = ex_bus.i_busA + w_opb;
      OpSub:   w_alu = ex_bus.i_busA - w_opb;
      OpAnd:   w_alu = ex_bus.i_busA & w_opb;
      OpOr:    w_alu = ex_bus.i_busA | w_opb;
      OpXor:   w_alu = ex_bus.i_busA ^ w_opb;
      OpNor:   w_alu = ~(ex_bus.i_busA | w_opb);
      OpSlt:   w_alu = {31'd0, $signed(ex_bus.i_busA) < $signed(w_opb)};
      OpSltu:  w_alu = {31'd0, ex_bus.i_busA < w_opb};
      OpSll:   w_alu = ex_bus.i_busB << w_shamt;
      OpSrl:   w_alu = ex_bus.i_busB >> w_shamt;
      OpSra:   w_alu = $unsigned($signed(ex_bus.i_busB) >>> w_shamt);
      OpLui:   w_alu = {ex_bus.i_imm32[15:0], 16'h0000};
      OpMfhi:  w_alu = w_hi;
      OpMflo:  w_alu = w_lo;
      default: w_alu = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_busB   <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_busB   <= ex_bus.i_busB;
      r_result <= w_md_op ? 32'd0 : w_alu;
      r_rd     <= w_md_op ? 5'd0 : ex_bus.i_rd;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  mdu u_mdu (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept && w_md_op),
    .i_flush (ex_bus.i_flush),
    .i_op    (ex_bus.i_aluop),
    .i_a     (ex_bus.i_busA),
    .i_b     (ex_bus.i_busB),
    .o_busy  (w_stall),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign ex_bus.o_valid  = r_valid;
  assign ex_bus.o_result = r_result;
  assign ex_bus.o_busB   = r_busB;
  assign ex_bus.o_rd     = r_rd;
  assign ex_bus.o_stall  = w_stall;

endmodule
